// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial sequencer around a single external 1-bit ALU slice.
// Operands are rotated LSB-first through the slice while the slice carry-out
// is carried forward in a register. An extra pass resolves set-less-than.
// The zero, carry and overflow flags are produced alongside the result.
//
// Optional feature macro: SERIAL_ALU_OVF_EN
//   defined   -> signed overflow flag is built and folded into the SLT set bit
//   undefined -> overflow_o reads 0 and SLT uses the MSB sum bit alone
module serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             slice_src1_o,
    output logic             slice_src2_o,
    output logic             slice_less_o,
    output logic             slice_A_invert_o,
    output logic             slice_B_invert_o,
    output logic             slice_cin_o,
    output logic [1:0]       slice_operation_o,
    input  logic             slice_result_i,
    input  logic             slice_cout_i
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] src1_sh_r;
    logic [WIDTH-1:0] src2_sh_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_nxt_s;
    logic [3:0]       ctrl_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             set_r;
    logic             cout_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;
    logic             last_bit_s;
    logic             is_slt_s;
    logic             res_bit_s;
    logic             set_nxt_s;
    logic             accept_s;

    assign accept_s   = (state_r == ST_IDLE) && start_i;
    assign last_bit_s = (cnt_r == CW'(WIDTH - 1));
    assign is_slt_s   = (ctrl_r[1:0] == 2'b11);

`ifdef SERIAL_ALU_OVF_EN
    logic ovf_raw_s;
    logic ovf_r;

    // Set bit for SLT: MSB difference corrected by signed overflow
    always_comb begin
        ovf_raw_s = carry_r ^ slice_cout_i;
        set_nxt_s = slice_result_i ^ ovf_raw_s;
    end

    // Overflow flag: cleared on accept, captured on the MSB pass for ADD/SUB only
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            ovf_r <= 1'b0;
        end else if ((state_r == ST_RUN) && last_bit_s) begin
            ovf_r <= (ctrl_r[1:0] == 2'b10) ? ovf_raw_s : 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign overflow_o = ovf_r;
`else
    // Set bit for SLT: MSB difference only (wrong when the subtraction overflows)
    always_comb begin
        set_nxt_s = slice_result_i;
    end

    assign overflow_o = 1'b0;
`endif

    // Next-state logic, slice drive and next result value
    always_comb begin
        state_nxt_s       = state_r;
        result_nxt_s      = result_r;
        res_bit_s         = 1'b0;
        slice_src1_o      = 1'b0;
        slice_src2_o      = 1'b0;
        slice_less_o      = 1'b0;
        slice_A_invert_o  = 1'b0;
        slice_B_invert_o  = 1'b0;
        slice_cin_o       = 1'b0;
        slice_operation_o = 2'b00;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                slice_src1_o     = src1_sh_r[0];
                slice_src2_o     = src2_sh_r[0];
                slice_A_invert_o = ctrl_r[3];
                slice_B_invert_o = ctrl_r[2];
                slice_cin_o      = carry_r;
                // SLT runs the subtraction first; the less path comes in the fix-up pass
                if (is_slt_s) begin
                    slice_operation_o = 2'b10;
                    res_bit_s         = 1'b0;
                end else begin
                    slice_operation_o = ctrl_r[1:0];
                    res_bit_s         = slice_result_i;
                end
                result_nxt_s[cnt_r] = res_bit_s;
                if (!last_bit_s) begin
                    state_nxt_s = ST_RUN;
                end else if (is_slt_s) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_FIX: begin
                // Operands have rotated all the way round, so bit 0 is back at the LSB
                slice_src1_o      = src1_sh_r[0];
                slice_src2_o      = src2_sh_r[0];
                slice_A_invert_o  = ctrl_r[3];
                slice_B_invert_o  = ctrl_r[2];
                slice_cin_o       = ctrl_r[2];
                slice_less_o      = set_r;
                slice_operation_o = 2'b11;
                result_nxt_s[0]   = slice_result_i;
                state_nxt_s       = ST_DONE;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Done pulse: high for exactly the cycle spent in DONE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Datapath: operand rotation, carry chain, result capture and flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src1_sh_r <= {WIDTH{1'b0}};
            src2_sh_r <= {WIDTH{1'b0}};
            result_r  <= {WIDTH{1'b0}};
            ctrl_r    <= 4'b0000;
            cnt_r     <= {CW{1'b0}};
            carry_r   <= 1'b0;
            set_r     <= 1'b0;
            cout_r    <= 1'b0;
            zero_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        src1_sh_r <= src1_i;
                        src2_sh_r <= src2_i;
                        ctrl_r    <= ctrl_i;
                        cnt_r     <= {CW{1'b0}};
                        carry_r   <= ctrl_i[2];
                        result_r  <= {WIDTH{1'b0}};
                        set_r     <= 1'b0;
                        cout_r    <= 1'b0;
                        zero_r    <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    result_r  <= result_nxt_s;
                    carry_r   <= slice_cout_i;
                    src1_sh_r <= {src1_sh_r[0], src1_sh_r[WIDTH-1:1]};
                    src2_sh_r <= {src2_sh_r[0], src2_sh_r[WIDTH-1:1]};
                    cnt_r     <= cnt_r + CW'(1);
                    if (last_bit_s) begin
                        cout_r <= slice_cout_i;
                        set_r  <= set_nxt_s;
                        if (!is_slt_s) begin
                            zero_r <= (result_nxt_s == {WIDTH{1'b0}});
                        end else begin
                            zero_r <= zero_r;
                        end
                    end else begin
                        cout_r <= cout_r;
                    end
                end
                ST_FIX: begin
                    result_r <= result_nxt_s;
                    zero_r   <= (result_nxt_s == {WIDTH{1'b0}});
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign result_o = result_r;
    assign zero_o   = zero_r;
    assign cout_o   = cout_r;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Testbench for serial_alu_ctrl (WIDTH=8) with a behavioural 1-bit slice
// and a word-level arithmetic reference model.
module tb_serial_alu_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   ctrl = 4'b0000;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic         busy, done, zero, cout, ovf;
    logic [W-1:0] result;
    logic         s_src1, s_src2, s_less, s_ainv, s_binv, s_cin;
    logic [1:0]   s_op;
    logic         s_result, s_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl),
        .src1_i(src1), .src2_i(src2),
        .busy_o(busy), .done_o(done), .result_o(result), .zero_o(zero),
        .cout_o(cout), .overflow_o(ovf),
        .slice_src1_o(s_src1), .slice_src2_o(s_src2), .slice_less_o(s_less),
        .slice_A_invert_o(s_ainv), .slice_B_invert_o(s_binv), .slice_cin_o(s_cin),
        .slice_operation_o(s_op),
        .slice_result_i(s_result), .slice_cout_i(s_cout)
    );

    // The external 1-bit ALU slice
    logic sa, sb;
    always_comb begin
        sa     = s_src1 ^ s_ainv;
        sb     = s_src2 ^ s_binv;
        s_cout = (sa & sb) | (sa & s_cin) | (sb & s_cin);
        case (s_op)
            2'b00:   s_result = sa & sb;
            2'b01:   s_result = sa | sb;
            2'b10:   s_result = sa ^ sb ^ s_cin;
            default: s_result = s_less;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: invert fields, then AND/OR/ADD/SLT on whole words
    function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic co, output logic ov,
                                  output logic z);
        logic [W-1:0] aa, bb;
        int unsigned  full, low;
        logic         cmsb, ovr, set;
        aa   = c[3] ? ~a : a;
        bb   = c[2] ? ~b : b;
        full = int'(aa) + int'(bb) + int'(c[2]);
        low  = int'(aa[W-2:0]) + int'(bb[W-2:0]) + int'(c[2]);
        co   = full[W];
        cmsb = low[W-1];
        ovr  = cmsb ^ co;
`ifdef SERIAL_ALU_OVF_EN
        set  = full[W-1] ^ ovr;
        ov   = (c[1:0] == 2'b10) ? ovr : 1'b0;
`else
        set  = full[W-1];
        ov   = 1'b0;
`endif
        case (c[1:0])
            2'b00:   r = aa & bb;
            2'b01:   r = aa | bb;
            2'b10:   r = full[W-1:0];
            default: r = {{(W-1){1'b0}}, set};
        endcase
        z = (r == '0);
    endfunction

    task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold_start);
        logic [W-1:0] er;
        logic         ec, eo, ez;
        int           lat;
        model(c, a, b, er, ec, eo, ez);
        @(negedge clk);
        start = 1'b1; ctrl = c; src1 = a; src2 = b;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        ctrl = 4'($urandom); src1 = W'($urandom); src2 = W'($urandom);
        chk("busy_after_accept", busy, 1'b1);
        chk("flags_clear", {zero, cout, ovf, done}, 4'b0000);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, (c[1:0] == 2'b11) ? 9 : 8);
        chk("result", result, er);
        chk("cout", cout, ec);
        chk("overflow", ovf, eo);
        chk("zero", zero, ez);
        chk("busy_in_done", busy, 1'b1);
        chk("slice_idle_done", {s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_op}, 8'h00);
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse_end", {done, busy}, 2'b00);
        @(posedge clk); #1;
        chk("no_requeue", {done, busy}, 2'b00);
        chk("result_hold", result, er);
    endtask

    initial begin
        #2;
        chk("rst_outs", {busy, done, zero, cout, ovf}, 5'b00000);
        chk("rst_result", result, 8'h00);
        chk("rst_slice", {s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_op}, 8'h00);
        @(negedge clk); rst = 1'b0;

        do_op(4'b0010, 8'h7F, 8'h01, 1'b0);
        do_op(4'b0110, 8'h05, 8'h05, 1'b0);
        do_op(4'b0111, 8'hFE, 8'h03, 1'b0);
        do_op(4'b0111, 8'h03, 8'hFE, 1'b0);
        do_op(4'b0111, 8'h80, 8'h01, 1'b0);
        do_op(4'b1100, 8'hF0, 8'h0C, 1'b0);
        do_op(4'b0000, 8'hF0, 8'h3C, 1'b0);
        do_op(4'b0001, 8'hF0, 8'h3C, 1'b0);
        do_op(4'b0010, 8'hFF, 8'h01, 1'b1);

        // Asynchronous reset in the middle of a subtraction
        @(negedge clk);
        start = 1'b1; ctrl = 4'b0110; src1 = 8'h0F; src2 = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_outs", {busy, done, zero, cout, ovf}, 5'b00000);
        chk("midrst_result", result, 8'h00);
        chk("midrst_slice", {s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_op}, 8'h00);
        @(negedge clk); rst = 1'b0;
        do_op(4'b0010, 8'h01, 8'h02, 1'b0);

        for (int i = 0; i < 30; i++) begin
            do_op(4'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
